// File: rtl/readout_pkt_decoder_if.sv
// Readout FIFO read port and host-side record handshake for the packet decoder.
// The master modport is the decoder; the slave modport is the FIFO/host environment.
interface readout_pkt_decoder_if;
  logic        FifoEmpty_i;
  logic [31:0] FifoRdData_i;
  logic        FifoRd_o;
  logic        RecValid_o;
  logic        RecReady_i;
  logic [4:0]  RecId_o;
  logic [4:0]  RecOsc_o;
  logic [23:0] RecData_o;
  logic        RecParErr_o;

  modport master (
    input  FifoEmpty_i, FifoRdData_i, RecReady_i,
    output FifoRd_o, RecValid_o, RecId_o, RecOsc_o, RecData_o, RecParErr_o
  );

  modport slave (
    output FifoEmpty_i, FifoRdData_i, RecReady_i,
    input  FifoRd_o, RecValid_o, RecId_o, RecOsc_o, RecData_o, RecParErr_o
  );
endinterface

// File: rtl/readout_pkt_decoder.sv
// Reassembles HEAD/BODY/TAIL readout words into parity-checked per-sample records.
// Statistics counters are built only when READOUT_DEC_STATS_EN is defined.
module readout_pkt_decoder #(
  parameter int NumOsc = 25
) (
  input  logic                         clk,
  input  logic                         rstn,
  readout_pkt_decoder_if.master        bus,
  output logic                         SeqErr_o,
  input  logic                         StatClr_i,
  output logic [15:0]                  PktCnt_o,
  output logic [7:0]                   ParErrCnt_o,
  output logic [7:0]                   SeqErrCnt_o
);

  localparam logic [1:0] W_HEAD = 2'd0;
  localparam logic [1:0] W_BODY = 2'd1;
  localparam logic [1:0] W_TAIL = 2'd2;
  localparam logic [1:0] EMIT   = 2'd3;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b11;

  function automatic logic [7:0] calc_par(input logic [23:0] d);
    logic [7:0] p;
    p[7] = ~(d[23] ^ d[19] ^ d[15] ^ d[11] ^ d[7] ^ d[3]);
    p[6] = ~(d[22] ^ d[18] ^ d[14] ^ d[10] ^ d[6] ^ d[2]);
    p[5] = ~(d[21] ^ d[17] ^ d[13] ^ d[9]  ^ d[5] ^ d[1]);
    p[4] = ~(d[20] ^ d[16] ^ d[12] ^ d[8]  ^ d[4] ^ d[0]);
    p[3] = ~^d[23:18];
    p[2] = ~^d[17:12];
    p[1] = ~^d[11:6];
    p[0] = ~^d[5:0];
    return p;
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_valid;
  logic        r_seqerr;
  logic [4:0]  r_hid;
  logic [4:0]  r_hosc;
  logic [23:0] r_bdata;
  logic [4:0]  r_rec_id;
  logic [4:0]  r_rec_osc;
  logic [23:0] r_rec_data;
  logic        r_rec_parerr;

  logic        w_pop;
  logic [1:0]  w_type;
  logic        w_head_ok;
  logic        w_load_head;
  logic        w_load_body;
  logic        w_emit;
  logic        w_seqerr;
  logic        w_accept;

  // No pops while a record is waiting; reset also blocks pops combinationally.
  assign w_pop     = ~bus.FifoEmpty_i & rstn & (r_state != EMIT);
  assign w_type    = bus.FifoRdData_i[31:30];
  assign w_head_ok = (w_type == T_HEAD) && (32'(bus.FifoRdData_i[4:0]) < NumOsc);
  assign w_accept  = r_valid & bus.RecReady_i;

  always_comb begin
    w_state_nxt = r_state;
    w_load_head = 1'b0;
    w_load_body = 1'b0;
    w_emit      = 1'b0;
    w_seqerr    = 1'b0;
    case (r_state)
      W_HEAD: if (w_pop) begin
        if (w_head_ok) begin
          w_load_head = 1'b1;
          w_state_nxt = W_BODY;
        end else begin
          w_seqerr = 1'b1;
        end
      end
      W_BODY, W_TAIL: if (w_pop) begin
        if (r_state == W_BODY && w_type == T_BODY) begin
          w_load_body = 1'b1;
          w_state_nxt = W_TAIL;
        end else if (r_state == W_TAIL && w_type == T_TAIL) begin
          w_emit      = 1'b1;
          w_state_nxt = EMIT;
        end else if (w_head_ok) begin
          w_seqerr    = 1'b1;
          w_load_head = 1'b1;
          w_state_nxt = W_BODY;
        end else begin
          w_seqerr    = 1'b1;
          w_state_nxt = W_HEAD;
        end
      end
      default: if (bus.RecReady_i) w_state_nxt = W_HEAD;
    endcase
  end

  // Control and record registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= W_HEAD;
      r_valid      <= 1'b0;
      r_seqerr     <= 1'b0;
      r_rec_id     <= '0;
      r_rec_osc    <= '0;
      r_rec_data   <= '0;
      r_rec_parerr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_emit | (r_valid & ~bus.RecReady_i);
      r_seqerr <= w_seqerr;
      if (w_emit) begin
        r_rec_id     <= r_hid;
        r_rec_osc    <= r_hosc;
        r_rec_data   <= r_bdata;
        r_rec_parerr <= (calc_par(r_bdata) != bus.FifoRdData_i[7:0]);
      end
    end
  end

  // In-progress packet fields; only read after being loaded by the FSM
  always_ff @(posedge clk) begin
    if (w_load_head) begin
      r_hid  <= bus.FifoRdData_i[9:5];
      r_hosc <= bus.FifoRdData_i[4:0];
    end
    if (w_load_body) r_bdata <= bus.FifoRdData_i[23:0];
  end

  assign bus.FifoRd_o    = w_pop;
  assign bus.RecValid_o  = r_valid;
  assign bus.RecId_o     = r_rec_id;
  assign bus.RecOsc_o    = r_rec_osc;
  assign bus.RecData_o   = r_rec_data;
  assign bus.RecParErr_o = r_rec_parerr;
  assign SeqErr_o        = r_seqerr;

`ifdef READOUT_DEC_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [7:0]  r_par_cnt;
  logic [7:0]  r_seq_cnt;
  logic        w_unused_bits;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pkt_cnt <= '0;
      r_par_cnt <= '0;
      r_seq_cnt <= '0;
    end else if (StatClr_i) begin
      r_pkt_cnt <= '0;
      r_par_cnt <= '0;
      r_seq_cnt <= '0;
    end else begin
      if (w_accept) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_accept && r_rec_parerr && r_par_cnt != 8'hFF) r_par_cnt <= r_par_cnt + 8'd1;
      if (w_seqerr && r_seq_cnt != 8'hFF) r_seq_cnt <= r_seq_cnt + 8'd1;
    end
  end

  assign PktCnt_o      = r_pkt_cnt;
  assign ParErrCnt_o   = r_par_cnt;
  assign SeqErrCnt_o   = r_seq_cnt;
  assign w_unused_bits = ^bus.FifoRdData_i[29:24];
`else
  logic w_unused_bits;

  assign PktCnt_o      = '0;
  assign ParErrCnt_o   = '0;
  assign SeqErrCnt_o   = '0;
  assign w_unused_bits = ^{bus.FifoRdData_i[29:24], StatClr_i, w_accept};
`endif

endmodule

// File: tb/tb_readout_pkt_decoder.sv
// Directed bench for readout_pkt_decoder: packet decode, parity, sequence errors,
// backpressure, reset mid-packet and statistics counters.
module tb_readout_pkt_decoder;

`ifdef READOUT_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        SeqErr_o;
  logic        StatClr_i;
  logic [15:0] PktCnt_o;
  logic [7:0]  ParErrCnt_o;
  logic [7:0]  SeqErrCnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  readout_pkt_decoder_if bus_if ();

  readout_pkt_decoder dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus_if),
    .SeqErr_o    (SeqErr_o),
    .StatClr_i   (StatClr_i),
    .PktCnt_o    (PktCnt_o),
    .ParErrCnt_o (ParErrCnt_o),
    .SeqErrCnt_o (SeqErrCnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // Present one word, confirm it is popped, and return at the next falling edge.
  task automatic pop(input logic [31:0] w);
    bus_if.FifoEmpty_i  = 1'b0;
    bus_if.FifoRdData_i = w;
    #1 check("fifo_rd_pop", 32'(bus_if.FifoRd_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.FifoEmpty_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rec(input string tag, input logic [4:0] id, input logic [4:0] osc,
                           input logic [23:0] data, input logic perr);
    check({tag, "_valid"}, 32'(bus_if.RecValid_o), 32'd1);
    check({tag, "_id"},    32'(bus_if.RecId_o),    32'(id));
    check({tag, "_osc"},   32'(bus_if.RecOsc_o),   32'(osc));
    check({tag, "_data"},  32'(bus_if.RecData_o),  32'(data));
    check({tag, "_perr"},  32'(bus_if.RecParErr_o), 32'(perr));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  32'(bus_if.RecValid_o),  32'd0);
    check({tag, "_id"},     32'(bus_if.RecId_o),     32'd0);
    check({tag, "_osc"},    32'(bus_if.RecOsc_o),    32'd0);
    check({tag, "_data"},   32'(bus_if.RecData_o),   32'd0);
    check({tag, "_perr"},   32'(bus_if.RecParErr_o), 32'd0);
    check({tag, "_seqerr"}, 32'(SeqErr_o),           32'd0);
    check({tag, "_fiford"}, 32'(bus_if.FifoRd_o),    32'd0);
    check({tag, "_pktcnt"}, 32'(PktCnt_o),           32'd0);
    check({tag, "_parcnt"}, 32'(ParErrCnt_o),        32'd0);
    check({tag, "_seqcnt"}, 32'(SeqErrCnt_o),        32'd0);
  endtask

  initial begin
    rstn                = 1'b0;
    StatClr_i           = 1'b0;
    bus_if.FifoEmpty_i  = 1'b0;
    bus_if.FifoRdData_i = 32'h000000A3;
    bus_if.RecReady_i   = 1'b0;
    @(negedge clk);
    step();
    check_zero("reset");
    bus_if.FifoEmpty_i = 1'b1;
    rstn               = 1'b1;
    step();

    // Clean packet: ID=5, Osc=3, data 0, parity 0xFF
    bus_if.RecReady_i = 1'b1;
    pop(32'h000000A3);
    check("t1_seqerr_head", 32'(SeqErr_o), 32'd0);
    pop(32'h40000000);
    check("t1_valid_early", 32'(bus_if.RecValid_o), 32'd0);
    pop(32'hC00000FF);
    check_rec("t1", 5'd5, 5'd3, 24'h000000, 1'b0);
    check("t1_emit_no_pop", 32'(bus_if.FifoRd_o), 32'd0);
    step();
    check("t1_valid_drop", 32'(bus_if.RecValid_o), 32'd0);
    check("t1_pktcnt", 32'(PktCnt_o), cnt(1));

    // All-ones data with wrong parity
    pop(32'h000000A3);
    pop(32'h40FFFFFF);
    pop(32'hC00000FE);
    check_rec("t2", 5'd5, 5'd3, 24'hFFFFFF, 1'b1);
    step();
    check("t2_parcnt", 32'(ParErrCnt_o), cnt(1));
    check("t2_pktcnt", 32'(PktCnt_o), cnt(2));

    // Stray BODY before a valid packet
    pop(32'h40000000);
    check("t3_seqerr", 32'(SeqErr_o), 32'd1);
    pop(32'h000000A3);
    check("t3_seqerr_one_cycle", 32'(SeqErr_o), 32'd0);
    pop(32'h40000000);
    pop(32'hC00000FF);
    check_rec("t3", 5'd5, 5'd3, 24'h000000, 1'b0);
    step();
    check("t3_seqcnt", 32'(SeqErrCnt_o), cnt(1));

    // HEAD arriving where TAIL was expected restarts the packet
    pop(32'h000000A3);
    pop(32'h40000000);
    pop(32'h00000041);
    check("t4_seqerr", 32'(SeqErr_o), 32'd1);
    check("t4_no_rec", 32'(bus_if.RecValid_o), 32'd0);
    pop(32'h40000007);
    check("t4_seqerr_clear", 32'(SeqErr_o), 32'd0);
    pop(32'hC000008E);
    check_rec("t4", 5'd2, 5'd1, 24'h000007, 1'b0);
    step();
    check("t4_seqcnt", 32'(SeqErrCnt_o), cnt(2));
    check("t4_pktcnt", 32'(PktCnt_o), cnt(4));

    // Backpressure with the next HEAD waiting in the FIFO
    bus_if.RecReady_i = 1'b0;
    pop(32'h000000A3);
    pop(32'h40FFFFFF);
    pop(32'hC00000FF);
    bus_if.FifoEmpty_i  = 1'b0;
    bus_if.FifoRdData_i = 32'h00000041;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t5_hold_fiford", 32'(bus_if.FifoRd_o), 32'd0);
      check_rec("t5_hold", 5'd5, 5'd3, 24'hFFFFFF, 1'b0);
      step();
    end
    bus_if.RecReady_i = 1'b1;
    step();
    check("t5_released", 32'(bus_if.RecValid_o), 32'd0);
    check("t5_fiford_resume", 32'(bus_if.FifoRd_o), 32'd1);
    pop(32'h00000041);
    pop(32'h40000007);
    pop(32'hC000008E);
    check_rec("t5_second", 5'd2, 5'd1, 24'h000007, 1'b0);
    step();
    check("t5_pktcnt", 32'(PktCnt_o), cnt(6));

    // Statistics clear
    StatClr_i = 1'b1;
    step();
    StatClr_i = 1'b0;
    check("clr_pktcnt", 32'(PktCnt_o), 32'd0);
    check("clr_parcnt", 32'(ParErrCnt_o), 32'd0);
    check("clr_seqcnt", 32'(SeqErrCnt_o), 32'd0);

    // Out-of-range oscillator, then reset mid-packet
    pop(32'h00000019);
    check("t6_osc_range_seqerr", 32'(SeqErr_o), 32'd1);
    pop(32'h000000A3);
    check("t6_seqerr_clear", 32'(SeqErr_o), 32'd0);
    check("t6_seqcnt", 32'(SeqErrCnt_o), cnt(1));
    pop(32'h40000000);
    bus_if.FifoEmpty_i  = 1'b0;
    bus_if.FifoRdData_i = 32'hC00000FF;
    rstn                = 1'b0;
    #1 check_zero("t6_midreset");
    step();
    bus_if.FifoEmpty_i = 1'b1;
    rstn               = 1'b1;
    step();
    check("t6_post_seqerr", 32'(SeqErr_o), 32'd0);
    check("t6_post_valid", 32'(bus_if.RecValid_o), 32'd0);
    pop(32'h00000041);
    pop(32'h40000007);
    pop(32'hC000008E);
    check_rec("t6", 5'd2, 5'd1, 24'h000007, 1'b0);
    step();
    check("t6_pktcnt", 32'(PktCnt_o), cnt(1));
    check("t6_seqcnt_after", 32'(SeqErrCnt_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
